// File: rtl/present_sbox_layer_serial.sv
// -----------------------------------------------------------------------------
// present_sbox_layer_serial
//
// Sequential PRESENT substitution layer. A STATE_W-bit cipher state is loaded,
// then LANES nibbles per cycle are passed through the PRESENT S-box (or its
// inverse), lowest nibbles first. After ITER = STATE_W/(4*LANES) cycles the
// complete result is presented with a valid/ready handshake.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   data_i       state to substitute (sampled on acceptance)
//   mode_i       0 = forward S-box, 1 = inverse S-box (sampled on acceptance)
//   in_valid_i   data_i/mode_i valid
//   in_ready_o   block idle and able to accept a new state
//   data_o       substituted state, meaningful while out_valid_o = 1
//   out_valid_o  data_o holds a complete result
//   out_ready_i  downstream accepts data_o
//   busy_o       substitution in progress
// -----------------------------------------------------------------------------
module present_sbox_layer_serial #(
   parameter int STATE_W = 64,
   parameter int LANES   = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [STATE_W-1:0] data_i,
   input  logic               mode_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [STATE_W-1:0] data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               busy_o
);

   localparam int GRP_W = 4 * LANES;
   localparam int ITER  = STATE_W / GRP_W;
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   if (LANES < 1 || (STATE_W % GRP_W) != 0) begin : g_param_check
      $error("present_sbox_layer_serial: STATE_W must be a multiple of 4*LANES");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   function automatic logic [3:0] sbox(input logic [3:0] nib, input logic inv);
      logic [3:0] r;
      if (!inv) begin
         case (nib)
            4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
            4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
            4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
            4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
         endcase
      end else begin
         case (nib)
            4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
            4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
            4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
            4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  default: r = 4'hA;
         endcase
      end
      return r;
   endfunction

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               mode_q;
   logic [STATE_W-1:0] data_q;
   logic [STATE_W-1:0] data_sub;
   logic [GRP_W-1:0]   grp_in;
   logic [GRP_W-1:0]   grp_out;
   logic               load;
   logic               step;

   // Next-state and control decode.
   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               load    = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            step = 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Select the nibble group addressed by the counter; only LANES S-boxes exist.
   always_comb begin
      grp_in = '0;
      for (int g = 0; g < ITER; g++) begin
         if (cnt_q == CNT_W'(g)) grp_in = data_q[g*GRP_W +: GRP_W];
      end
   end

   always_comb begin
      grp_out = '0;
      for (int l = 0; l < LANES; l++) begin
         grp_out[l*4 +: 4] = sbox(grp_in[l*4 +: 4], mode_q);
      end
   end

   // Write the substituted group back in place; all other nibbles pass through.
   always_comb begin
      data_sub = data_q;
      for (int g = 0; g < ITER; g++) begin
         if (cnt_q == CNT_W'(g)) data_sub[g*GRP_W +: GRP_W] = grp_out;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         // NOTE: the data register is reset because it drives data_o directly
         // and data_o must read zero out of reset; a pure pipeline register
         // would normally be left unreset.
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data_q <= data_i;
            mode_q <= mode_i;
            cnt_q  <= '0;
         end else if (step) begin
            data_q <= data_sub;
            cnt_q  <= cnt_q + CNT_W'(1);
         end
      end
   end

   // All outputs come straight from registers or the state decode.
   assign in_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q == S_BUSY);
   assign out_valid_o = (state_q == S_DONE);
   assign data_o      = data_q;

endmodule

// File: tb/tb_present_sbox_layer_serial.sv
// -----------------------------------------------------------------------------
// tb_present_sbox_layer_serial
//
// Five DUT configurations (64/4, 64/1, 64/2, 64/16, 128/8) run side by side.
// Stimulus pushes expected results into a per-instance queue; a per-instance
// monitor pops and compares whenever out_valid_o is seen, and checks latency
// on the first valid cycle of each block. Instance 0 also gets directed tests:
// known vectors, backpressure, mid-operation reset and input isolation.
// -----------------------------------------------------------------------------
module tb_present_sbox_layer_serial;

   localparam int NI = 5;
   localparam int SW [NI] = '{64, 64, 64, 64, 128};
   localparam int LN [NI] = '{4, 1, 2, 16, 8};

   localparam logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   localparam logic [3:0] INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                       4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

   typedef struct {
      logic [127:0] data;
      int           acc;
   } exp_t;

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   initial forever @(posedge clk) cyc++;

   logic [NI-1:0][127:0] din;
   logic [NI-1:0][127:0] dout;
   logic [NI-1:0]        mode;
   logic [NI-1:0]        ivld;
   logic [NI-1:0]        irdy;
   logic [NI-1:0]        ov;
   logic [NI-1:0]        busy;
   logic [NI-1:0]        rstn;
   bit                   stall    [NI];
   bit                   rand_rdy [NI];
   exp_t                 sb [NI][$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   // Reference: apply the table to every nibble of a w-bit state.
   function automatic logic [127:0] ref_sub(input logic [127:0] d, input int w, input bit m);
      logic [127:0] r;
      logic [3:0]   nib;
      r = '0;
      for (int n = 0; n < w / 4; n++) begin
         nib = d[n*4 +: 4];
         r[n*4 +: 4] = m ? INV[nib] : FWD[nib];
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W  = SW[gi];
      localparam int IT = SW[gi] / (4 * LN[gi]);
      logic [W-1:0] d_o;
      logic         ordy_l;

      present_sbox_layer_serial #(
         .STATE_W (W),
         .LANES   (LN[gi])
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rstn[gi]),
         .data_i      (din[gi][W-1:0]),
         .mode_i      (mode[gi]),
         .in_valid_i  (ivld[gi]),
         .in_ready_o  (irdy[gi]),
         .data_o      (d_o),
         .out_valid_o (ov[gi]),
         .out_ready_i (ordy_l),
         .busy_o      (busy[gi])
      );

      assign dout[gi] = 128'(d_o);

      initial begin : monitor
         bit cont;
         cont   = 1'b0;
         ordy_l = 1'b1;
         forever begin
            @(negedge clk);
            if (!rstn[gi]) begin
               cont = 1'b0;
            end else begin
               ordy_l = stall[gi] ? 1'b0 : (rand_rdy[gi] ? ($urandom_range(0, 3) != 0) : 1'b1);
               if (ov[gi]) begin
                  if (sb[gi].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_output[%0d]: out_valid_o=1 data %h, required no output",
                              gi, dout[gi]);
                  end else begin
                     if (!cont)
                        check($sformatf("latency[%0d]", gi), 128'(cyc - sb[gi][0].acc), 128'(IT));
                     check($sformatf("data[%0d]", gi), dout[gi], sb[gi][0].data);
                     if (ordy_l) void'(sb[gi].pop_front());
                  end
               end
               cont = ov[gi] && !ordy_l;
            end
         end
      end
   end

   // Present a block and wait until it is accepted; returns just after the
   // accepting edge with in_valid still asserted.
   task automatic issue(input int i, input logic [127:0] d, input bit m, input logic [127:0] e);
      bit   ok;
      exp_t x;
      ok = 1'b0;
      @(negedge clk);
      ivld[i] = 1'b1;
      din[i]  = d;
      mode[i] = m;
      for (int t = 0; t < 64; t++) begin
         if (irdy[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         x.data = e;
         x.acc  = cyc + 1;
         sb[i].push_back(x);
         @(posedge clk);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout[%0d]: in_ready_o stayed 0, required 1 within 64 cycles", i);
         ivld[i] = 1'b0;
      end
   endtask

   task automatic idle(input int i);
      @(negedge clk);
      ivld[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      for (int t = 0; t < 600; t++) begin
         if (sb[i].size() == 0) break;
         @(negedge clk);
      end
      if (sb[i].size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout[%0d]: %0d results pending, required 0", i, sb[i].size());
      end
   endtask

   task automatic run_random(input int i, input int n);
      logic [127:0] d;
      bit           m;
      d = {2{64'h0123456789ABCDEF}};
      issue(i, d, 1'b0, ref_sub(d, SW[i], 1'b0));
      for (int k = 0; k < n; k++) begin
         d = rand128();
         m = 1'($urandom_range(0, 1));
         issue(i, d, m, ref_sub(d, SW[i], m));
         if ($urandom_range(0, 3) == 0) idle(i);
      end
      idle(i);
   endtask

   initial begin : main
      logic [127:0] d;
      rstn = '0;
      ivld = '0;
      mode = '0;
      din  = '0;
      for (int i = 0; i < NI; i++) begin
         stall[i]    = 1'b0;
         rand_rdy[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_in_ready[%0d]", i), 128'(irdy[i]), 128'(1));
         check($sformatf("rst_out_valid[%0d]", i), 128'(ov[i]), 128'(0));
         check($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
         check($sformatf("rst_data[%0d]", i), dout[i], 128'(0));
      end
      @(posedge clk);
      #2 rstn = '1;

      // Known forward vector with busy window check.
      issue(0, 128'h0123456789ABCDEF, 1'b0, 128'hC56B90AD3EF84712);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         ivld[0] = 1'b0;
         check($sformatf("busy_high_%0d", j), 128'(busy[0]), 128'(1));
      end
      @(negedge clk);
      check("busy_low_done", 128'(busy[0]), 128'(0));
      check("valid_in_done", 128'(ov[0]), 128'(1));
      drain(0);

      issue(0, 128'hC56B90AD3EF84712, 1'b1, 128'h0123456789ABCDEF);
      idle(0);
      issue(0, 128'h0, 1'b0, 128'hCCCCCCCCCCCCCCCC);
      idle(0);
      drain(0);

      // Backpressure: result held, new input ignored while stalled.
      @(posedge clk);
      #1 stall[0] = 1'b1;
      d = rand128();
      issue(0, d, 1'b0, ref_sub(d, 64, 1'b0));
      idle(0);
      for (int t = 0; t < 20; t++) begin
         if (ov[0]) break;
         @(negedge clk);
      end
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         check("stall_in_ready", 128'(irdy[0]), 128'(0));
         check("stall_valid", 128'(ov[0]), 128'(1));
         if (j == 3) begin
            ivld[0] = 1'b1;
            din[0]  = rand128();
            mode[0] = 1'b1;
         end else begin
            ivld[0] = 1'b0;
         end
      end
      @(posedge clk);
      #1 stall[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("release_in_ready", 128'(irdy[0]), 128'(1));
      check("release_valid", 128'(ov[0]), 128'(0));
      drain(0);

      // Reset two cycles after acceptance discards the block.
      d = rand128();
      issue(0, d, 1'b0, ref_sub(d, 64, 1'b0));
      @(negedge clk);
      ivld[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rstn[0] = 1'b0;
      #1;
      check("midrst_in_ready", 128'(irdy[0]), 128'(1));
      check("midrst_valid", 128'(ov[0]), 128'(0));
      check("midrst_busy", 128'(busy[0]), 128'(0));
      check("midrst_data", dout[0], 128'(0));
      sb[0].delete();
      @(posedge clk);
      #2 rstn[0] = 1'b1;
      repeat (8) @(negedge clk);
      d = rand128();
      issue(0, d, 1'b1, ref_sub(d, 64, 1'b1));
      idle(0);
      drain(0);

      // Inputs wiggled during BUSY must not leak into the result.
      d = rand128();
      issue(0, d, 1'b0, ref_sub(d, 64, 1'b0));
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         ivld[0] = 1'b0;
         din[0]  = rand128();
         mode[0] = ~mode[0];
      end
      drain(0);

      // Random back-to-back blocks on every configuration.
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) rand_rdy[i] = 1'b1;
      for (int i = 0; i < NI; i++) begin
         fork
            automatic int j = i;
            run_random(j, 25);
         join_none
      end
      wait fork;
      for (int i = 0; i < NI; i++) drain(i);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/present_sbox_layer_serial.md
# present_sbox_layer_serial

Parametrised, sequential PRESENT substitution layer. It applies the 4-bit PRESENT S-box, or its inverse, to every nibble of a STATE_W-bit cipher state. LANES S-boxes are used per cycle, so area and latency can be traded against each other. It sits between the round-key XOR and the permutation layer in the round datapath, with valid/ready handshakes on both sides.

## Interface
Parameters:
- STATE_W, 64, cipher state width in bits; must be a multiple of 4*LANES, otherwise elaboration fails
- LANES, 4, S-box instances evaluated per cycle; range 1..STATE_W/4

Derived constant:
- ITER = STATE_W/(4*LANES), the number of substitution cycles per block (default 4)

Ports:
- clk_i, input, 1, single clock; all state updates on its rising edge
- rst_ni, input, 1, reset; **asynchronous, active-low**
- data_i, input, STATE_W, state to substitute
- mode_i, input, 1, 0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled with data_i
- in_valid_i, input, 1, data_i/mode_i valid
- in_ready_o, output, 1, block can accept a new state
- data_o, output, STATE_W, substituted state; meaningful only while out_valid_o = 1
- out_valid_o, output, 1, data_o holds a complete result
- out_ready_i, input, 1, downstream accepts data_o
- busy_o, output, 1, substitution in progress

## Operation
Forward table, input 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.

Inverse table, input 0..F: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.

FSM states: IDLE, BUSY, DONE.
- **IDLE:** in_ready_o = 1.
  - On in_valid_i & in_ready_o: load data_i into the state register, latch mode_i, clear the nibble counter, go to BUSY.
- **BUSY:** busy_o = 1.
  - Each cycle, replace the LANES nibbles at indices cnt*LANES .. cnt*LANES+LANES-1 with their S-box output, using the latched mode. Nibble 0 is bits [3:0]; lowest nibbles are processed first.
  - Increment cnt.
  - When cnt = ITER-1, perform that cycle's substitution and go to DONE.
- **DONE:** out_valid_o = 1.
  - data_o = state register, held stable while out_ready_i = 0.
  - On out_ready_i, go to IDLE.

Other rules:
- in_ready_o is 0 in BUSY and DONE. in_valid_i is ignored there, and data_i/mode_i changes have no effect.
- mode_i changes after acceptance do not affect the block in flight.
- The counter width is clog2(ITER), minimum 1 bit. The counter wraps only by being cleared on acceptance.
- LANES = STATE_W/4 (ITER = 1): one BUSY cycle. There is still no combinational path from data_i to data_o.
- Reset asserted in any state, including mid-BUSY: immediately go to IDLE, clear cnt, state register and latched mode. The partial result is discarded and never presented.
- Reset values: in_ready_o = 1, out_valid_o = 0, busy_o = 0, data_o = 0.

## Timing
- Acceptance at rising edge k. busy_o is high for cycles k..k+ITER-1 (edge-relative). out_valid_o rises after edge k+ITER.
- Latency from acceptance edge to first out_valid_o cycle: ITER edges (default 4).
- Output handshake at edge m: out_valid_o falls and in_ready_o rises in the cycle after edge m. The next acceptance is possible at edge m+1.
- Sustained throughput with out_ready_i held high: one block per ITER+2 cycles.
- All outputs are registered or decoded directly from the FSM state. No combinational path exists from any input to any output.
- A downstream stall in DONE holds data_o and out_valid_o unchanged indefinitely.

## Test plan
- **Forward, default params:** data_i = 64'h0123456789ABCDEF, mode_i = 0 -> data_o = 64'hC56B90AD3EF84712, out_valid_o exactly 4 edges after acceptance.
- **Inverse round-trip:** data_i = 64'hC56B90AD3EF84712, mode_i = 1 -> data_o = 64'h0123456789ABCDEF. Also all-zero input, mode 0 -> 64'hCCCCCCCCCCCCCCCC.
- **Backpressure:** hold out_ready_i = 0 for 10 cycles in DONE -> data_o stable, in_ready_o = 0, and an in_valid_i pulse with new data_i is not accepted. Release -> in_ready_o = 1 next cycle.
- **Mid-operation reset:** assert rst_ni = 0 two cycles after acceptance -> outputs take reset values immediately, no out_valid_o afterwards. The next block is processed correctly.
- **Parameter sweep:** LANES = 1, 2, 16 with STATE_W = 64, plus STATE_W = 128 with LANES = 8 -> latency = ITER edges and the result matches the per-nibble table. Random back-to-back blocks are checked against a reference model.
- **Mode isolation:** toggle mode_i and data_i every cycle during BUSY -> result uses only the values sampled at acceptance.
